alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised multi-cycle successor to the single-cycle MIPS ALU. It executes every existing single-cycle operation in one clock and adds arithmetic shift, signed and unsigned set-less-than, unsigned multiply and unsigned divide. Multiply and divide are iterative and controlled by a start/busy/done handshake. It sits in the execute stage of the multi-cycle datapath, driven by the control FSM.

## Interface
Parameters:
- DATA_WIDTH, 32: operand/result width; must be even and ≥ 8.
- SHAMT_WIDTH, $clog2(DATA_WIDTH): shift-amount width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- start_i  in  1  launch operation; sampled only when busy_o=0.
- alu_operation_i  in  4  opcode.
- a_i  in  DATA_WIDTH  operand A.
- b_i  in  DATA_WIDTH  operand B.
- shamt_i  in  SHAMT_WIDTH  shift amount.
- busy_o  out  1  multi-cycle operation in progress.
- done_o  out  1  one-cycle pulse: result valid.
- alu_data_o  out  DATA_WIDTH  result (MULTU low word / DIVU quotient).
- hi_o  out  DATA_WIDTH  MULTU high word / DIVU remainder.
- zero_o  out  1  alu_data_o == 0.
- overflow_o  out  1  signed overflow (ADD/SUB only).

## Operation
Opcodes:
- Unchanged encodings:
  - ADD 0011 (LW alias 1010 = ADD).
  - ORI 0001.
  - SLL 0010.
  - SUB 0100.
  - SRL 0101.
  - AND 0111.
  - NOR 1000.
  - LUI 0110: b_i[DATA_WIDTH/2-1:0] shifted up by DATA_WIDTH/2, low half zeroed.
- New single-cycle ops:
  - SRA 1001: b_i arithmetic right shift by shamt_i.
  - SLT 1011: signed a<b → 1, else 0.
  - SLTU 1110: unsigned compare, same result format.
- New multi-cycle ops:
  - MULTU 1100: shift-add, one bit per cycle, 2·DATA_WIDTH product.
  - DIVU 1101: restoring division, one bit per cycle.
- Any other opcode: result 0, zero_o=1, done_o still pulses.

FSM, two states:
- IDLE: busy_o=0.
  - start_i with a single-cycle op → result registered, done_o=1 next cycle, remain IDLE. Back-to-back starts allowed; throughput is 1 per cycle.
  - start_i with MULTU/DIVU → capture a_i/b_i, load iteration counter with DATA_WIDTH-1, go to CALC.
- CALC: busy_o=1; one iteration per cycle. When the counter reaches 0: register the result, pulse done_o, return to IDLE.

Result and flag rules:
- Operands are captured at start; input changes during CALC are ignored. start_i during CALC is ignored (not queued).
- Outputs hold their value until the next done_o.
- hi_o updates only on MULTU/DIVU completion; it holds its value across single-cycle ops.
- zero_o and overflow_o update together with alu_data_o. overflow_o is 0 for all ops except ADD/SUB.
- Arithmetic: ADD/SUB wrap modulo 2^DATA_WIDTH. Overflow = operand signs equal (ADD) or differ (SUB), and the result sign differs from a_i.
- Divide by zero: quotient all ones, remainder = a_i, latency unchanged.
- Reset (any time, including mid-CALC): abort, state IDLE, all outputs 0, counter 0.

## Timing
- Single-cycle op: start_i sampled at edge E0 → alu_data_o/zero_o/overflow_o/done_o valid after E0. done_o is high for exactly one cycle unless another start follows.
- MULTU/DIVU: start_i sampled at E0 → busy_o high after E0. Iterations occur at E1..E(DATA_WIDTH).
  - At E(DATA_WIDTH): result, hi_o and done_o assert; busy_o deasserts.
  - Latency is DATA_WIDTH cycles.
  - A new start is accepted at E(DATA_WIDTH+1) at the earliest.
- done_o and busy_o are never high together.
- No combinational path from inputs to outputs.

## Structure
- Package alu_seq_pkg: opcode localparams (all 15 encodings), FSM state enum {IDLE, CALC}.
- Sub-module alu_muldiv_iter: iterative MULTU/DIVU datapath.
  - Holds the accumulator/remainder, operand shift registers and the iteration counter.
  - Ports: start, op select, operands; returns product/quotient and remainder with a last-iteration flag.
- Single-cycle datapath and FSM live in the top module.

## Test plan (DATA_WIDTH=32)
- ADD a=0x7FFFFFFF b=1 → alu_data_o=0x80000000, overflow_o=1, zero_o=0, done_o one cycle after start. SUB 5−5 → 0, zero_o=1, overflow_o=0.
- SRA b=0x80000000 shamt=4 → 0xF8000000. SLT a=0xFFFFFFFF b=1 → 1. SLTU same operands → 0. LUI b=0x1234 → 0x12340000.
- MULTU 0xFFFFFFFF×0xFFFFFFFF → busy_o 32 cycles, then hi_o=0xFFFFFFFE, alu_data_o=0x00000001. A start_i pulse at cycle 5 with ADD is ignored.
- DIVU 100/7 → alu_data_o=14, hi_o=2 at cycle 32. DIVU 9/0 → alu_data_o=0xFFFFFFFF, hi_o=9.
- Back-to-back ADD, AND, OR on consecutive cycles → three consecutive done_o pulses with correct results. A following unknown opcode 1111 → 0, zero_o=1.
- Reset asserted at cycle 10 of MULTU → busy_o=0 and all outputs 0 immediately. ADD 2+3 started after release → 5 on the next cycle.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcodes and FSM state type shared by the sequential ALU
package alu_seq_pkg;
    localparam logic [3:0] OP_NOP   = 4'b0000;
    localparam logic [3:0] OP_ORI   = 4'b0001;
    localparam logic [3:0] OP_SLL   = 4'b0010;
    localparam logic [3:0] OP_ADD   = 4'b0011;
    localparam logic [3:0] OP_SUB   = 4'b0100;
    localparam logic [3:0] OP_SRL   = 4'b0101;
    localparam logic [3:0] OP_LUI   = 4'b0110;
    localparam logic [3:0] OP_AND   = 4'b0111;
    localparam logic [3:0] OP_NOR   = 4'b1000;
    localparam logic [3:0] OP_SRA   = 4'b1001;
    localparam logic [3:0] OP_LW    = 4'b1010;
    localparam logic [3:0] OP_SLT   = 4'b1011;
    localparam logic [3:0] OP_MULTU = 4'b1100;
    localparam logic [3:0] OP_DIVU  = 4'b1101;
    localparam logic [3:0] OP_SLTU  = 4'b1110;
    typedef enum logic {IDLE, CALC} state_t;
endpackage

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: one-bit-per-cycle shift-add multiplier and restoring divider
module alu_muldiv_iter #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  en,
    input  logic                  div,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] lo_next,
    output logic [DATA_WIDTH-1:0] hi_next,
    output logic                  last
);
    localparam int CW = $clog2(DATA_WIDTH);
    logic [DATA_WIDTH-1:0] hi_r, lo_r, b_r, diff;
    logic [DATA_WIDTH:0]   sum, t;
    logic                  div_r, ge;
    logic [CW-1:0]         cnt;
    // lo_r holds the multiplier / dividend and collects product low bits / quotient bits
    always_comb begin
        sum     = {1'b0, hi_r} + (lo_r[0] ? {1'b0, b_r} : '0);
        t       = {hi_r, lo_r[DATA_WIDTH-1]};
        diff    = t[DATA_WIDTH-1:0] - b_r;
        ge      = t >= {1'b0, b_r};
        hi_next = div_r ? (ge ? diff : t[DATA_WIDTH-1:0]) : sum[DATA_WIDTH:1];
        lo_next = div_r ? {lo_r[DATA_WIDTH-2:0], ge} : {sum[0], lo_r[DATA_WIDTH-1:1]};
    end
    assign last = en && cnt == '0;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_r  <= '0;
            lo_r  <= '0;
            b_r   <= '0;
            div_r <= 1'b0;
            cnt   <= '0;
        end else if (start) begin
            hi_r  <= '0;
            lo_r  <= a;
            b_r   <= b;
            div_r <= div;
            cnt   <= CW'(DATA_WIDTH - 1);
        end else if (en) begin
            hi_r <= hi_next;
            lo_r <= lo_next;
            if (!last) cnt <= cnt - 1'b1;
        end
    end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle MIPS ALU with single-cycle ops and iterative MULTU/DIVU
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start_i,
    input  logic [3:0]             alu_operation_i,
    input  logic [DATA_WIDTH-1:0]  a_i,
    input  logic [DATA_WIDTH-1:0]  b_i,
    input  logic [SHAMT_WIDTH-1:0] shamt_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [DATA_WIDTH-1:0]  alu_data_o,
    output logic [DATA_WIDTH-1:0]  hi_o,
    output logic                   zero_o,
    output logic                   overflow_o
);
    localparam int H = DATA_WIDTH / 2;
    state_t                state;
    logic [DATA_WIDTH-1:0] res, sum, dif, md_lo, md_hi;
    logic                  ov, is_md, md_start, md_last;
    assign is_md    = alu_operation_i == OP_MULTU || alu_operation_i == OP_DIVU;
    assign md_start = state == IDLE && start_i && is_md;
    assign busy_o   = state == CALC;
    assign sum      = a_i + b_i;
    assign dif      = a_i - b_i;
    always_comb begin
        res = '0;
        ov  = 1'b0;
        case (alu_operation_i)
            OP_ADD, OP_LW: begin
                res = sum;
                ov  = a_i[DATA_WIDTH-1] == b_i[DATA_WIDTH-1] && sum[DATA_WIDTH-1] != a_i[DATA_WIDTH-1];
            end
            OP_SUB: begin
                res = dif;
                ov  = a_i[DATA_WIDTH-1] != b_i[DATA_WIDTH-1] && dif[DATA_WIDTH-1] != a_i[DATA_WIDTH-1];
            end
            OP_ORI:  res = a_i | b_i;
            OP_AND:  res = a_i & b_i;
            OP_NOR:  res = ~(a_i | b_i);
            OP_SLL:  res = b_i << shamt_i;
            OP_SRL:  res = b_i >> shamt_i;
            OP_SRA:  res = $signed(b_i) >>> shamt_i;
            OP_LUI:  res = {b_i[H-1:0], {H{1'b0}}};
            OP_SLT:  res = {{(DATA_WIDTH-1){1'b0}}, $signed(a_i) < $signed(b_i)};
            OP_SLTU: res = {{(DATA_WIDTH-1){1'b0}}, a_i < b_i};
            default: res = '0;
        endcase
    end
    alu_muldiv_iter #(.DATA_WIDTH(DATA_WIDTH)) u_iter (
        .clk     (clk),
        .reset   (reset),
        .start   (md_start),
        .en      (busy_o),
        .div     (alu_operation_i == OP_DIVU),
        .a       (a_i),
        .b       (b_i),
        .lo_next (md_lo),
        .hi_next (md_hi),
        .last    (md_last)
    );
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            done_o     <= 1'b0;
            alu_data_o <= '0;
            hi_o       <= '0;
            zero_o     <= 1'b0;
            overflow_o <= 1'b0;
        end else begin
            done_o <= 1'b0;
            if (state == IDLE) begin
                if (md_start) begin
                    state <= CALC;
                end else if (start_i) begin
                    alu_data_o <= res;
                    zero_o     <= res == '0;
                    overflow_o <= ov;
                    done_o     <= 1'b1;
                end
            end else if (md_last) begin
                state      <= IDLE;
                alu_data_o <= md_lo;
                hi_o       <= md_hi;
                zero_o     <= md_lo == '0;
                overflow_o <= 1'b0;
                done_o     <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq at DATA_WIDTH=32
module tb_alu_seq;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start_i = 1'b0;
    logic [3:0]  alu_operation_i = 4'b0;
    logic [31:0] a_i = '0, b_i = '0;
    logic [4:0]  shamt_i = '0;
    logic        busy_o, done_o, zero_o, overflow_o;
    logic [31:0] alu_data_o, hi_o;
    int          checks = 0, errors = 0;

    alu_seq #(.DATA_WIDTH(32)) dut (
        .clk             (clk),
        .reset           (reset),
        .start_i         (start_i),
        .alu_operation_i (alu_operation_i),
        .a_i             (a_i),
        .b_i             (b_i),
        .shamt_i         (shamt_i),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .alu_data_o      (alu_data_o),
        .hi_o            (hi_o),
        .zero_o          (zero_o),
        .overflow_o      (overflow_o)
    );

    always #5 clk = ~clk;

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
        @(negedge clk);
        alu_operation_i = op;
        a_i = a;
        b_i = b;
        shamt_i = sh;
        start_i = 1'b1;
    endtask

    task automatic single(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh,
                          input logic [31:0] exp, input string name);
        issue(op, a, b, sh);
        @(negedge clk);
        start_i = 1'b0;
        checks++;
        if (alu_data_o !== exp || done_o !== 1'b1) begin
            errors++;
            $display("FAIL %s data=%h done=%b expected data=%h done=1", name, alu_data_o, done_o, exp);
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy_o, done_o, zero_o, overflow_o, alu_data_o, hi_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got busy=%b done=%b data=%h hi=%h expected all 0", busy_o, done_o, alu_data_o, hi_o);
        end
        reset = 1'b1;
    endtask

    task automatic test_add_sub;
        single(4'b0011, 32'h7FFFFFFF, 32'h1, 5'd0, 32'h80000000, "add_data");
        checks++;
        if (overflow_o !== 1'b1 || zero_o !== 1'b0) begin
            errors++;
            $display("FAIL add_flags ovf=%b zero=%b expected ovf=1 zero=0", overflow_o, zero_o);
        end
        @(negedge clk);
        checks++;
        if (done_o !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse got %b expected 0", done_o);
        end
        single(4'b0100, 32'd5, 32'd5, 5'd0, 32'h0, "sub_data");
        checks++;
        if (overflow_o !== 1'b0 || zero_o !== 1'b1) begin
            errors++;
            $display("FAIL sub_flags ovf=%b zero=%b expected ovf=0 zero=1", overflow_o, zero_o);
        end
    endtask

    task automatic test_single_new;
        single(4'b1001, 32'h0, 32'h80000000, 5'd4, 32'hF8000000, "sra");
        single(4'b1011, 32'hFFFFFFFF, 32'h1, 5'd0, 32'h1, "slt");
        single(4'b1110, 32'hFFFFFFFF, 32'h1, 5'd0, 32'h0, "sltu");
        single(4'b0110, 32'h0, 32'h1234, 5'd0, 32'h12340000, "lui");
        single(4'b0010, 32'h0, 32'h3, 5'd4, 32'h30, "sll");
        single(4'b1000, 32'hF0F0F0F0, 32'h0F0F0000, 5'd0, 32'h0000_0F0F, "nor");
    endtask

    task automatic run_md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_lo, input logic [31:0] exp_hi, input string name, input bit poke);
        int n = 0;
        bit both = 0;
        issue(op, a, b, 5'd0);
        @(negedge clk);
        start_i = 1'b0;
        checks++;
        if (busy_o !== 1'b1) begin
            errors++;
            $display("FAIL %s_busy got %b expected 1", name, busy_o);
        end
        for (int i = 1; i <= 100; i++) begin
            if (poke && i == 5) begin
                alu_operation_i = 4'b0011;
                a_i = 32'd1;
                b_i = 32'd1;
                start_i = 1'b1;
            end
            @(negedge clk);
            start_i = 1'b0;
            if (busy_o && done_o) both = 1;
            if (done_o) begin
                n = i;
                break;
            end
        end
        checks++;
        if (n != 32 || both) begin
            errors++;
            $display("FAIL %s_latency got %0d (busy&done=%b) expected 32", name, n, both);
        end
        checks++;
        if (alu_data_o !== exp_lo || hi_o !== exp_hi || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL %s_result lo=%h hi=%h busy=%b expected lo=%h hi=%h busy=0", name, alu_data_o, hi_o, busy_o, exp_lo, exp_hi);
        end
    endtask

    task automatic test_muldiv;
        run_md(4'b1100, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, "multu", 1);
        checks++;
        if (zero_o !== 1'b0 || overflow_o !== 1'b0) begin
            errors++;
            $display("FAIL multu_flags zero=%b ovf=%b expected 0 0", zero_o, overflow_o);
        end
        run_md(4'b1101, 32'd100, 32'd7, 32'd14, 32'd2, "divu", 0);
        run_md(4'b1101, 32'd9, 32'd0, 32'hFFFFFFFF, 32'd9, "divu0", 0);
    endtask

    task automatic test_back_to_back;
        logic [3:0]  ops [4] = '{4'b0011, 4'b0111, 4'b0001, 4'b1111};
        logic [31:0] as  [4] = '{32'd10, 32'h0000F0F0, 32'h000000F0, 32'h12345678};
        logic [31:0] bs  [4] = '{32'd20, 32'h0000FF00, 32'h0000000F, 32'h9ABCDEF0};
        logic [31:0] ex  [4] = '{32'd30, 32'h0000F000, 32'h000000FF, 32'h0};
        issue(ops[0], as[0], bs[0], 5'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i < 3) begin
                alu_operation_i = ops[i+1];
                a_i = as[i+1];
                b_i = bs[i+1];
            end else start_i = 1'b0;
            checks++;
            if (done_o !== 1'b1 || alu_data_o !== ex[i] || zero_o !== (ex[i] == 0)) begin
                errors++;
                $display("FAIL b2b_%0d done=%b data=%h zero=%b expected done=1 data=%h", i, done_o, alu_data_o, zero_o, ex[i]);
            end
        end
        checks++;
        if (hi_o !== 32'd9) begin
            errors++;
            $display("FAIL hi_hold got %h expected 00000009", hi_o);
        end
        @(negedge clk);
        checks++;
        if (done_o !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end_done got %b expected 0", done_o);
        end
    endtask

    task automatic test_reset_mid;
        issue(4'b1100, 32'd3, 32'd5, 5'd0);
        @(negedge clk);
        start_i = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if ({busy_o, done_o, zero_o, overflow_o, alu_data_o, hi_o} !== '0) begin
            errors++;
            $display("FAIL reset_mid busy=%b done=%b data=%h hi=%h expected all 0", busy_o, done_o, alu_data_o, hi_o);
        end
        @(negedge clk);
        reset = 1'b1;
        single(4'b0011, 32'd2, 32'd3, 5'd0, 32'd5, "add_after_reset");
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL busy_after_reset got %b expected 0", busy_o);
        end
    endtask

    initial begin
        test_reset;
        test_add_sub;
        test_single_new;
        test_muldiv;
        test_back_to_back;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
